// File: rtl/fifo_rd_arbiter.sv
// Round-robin arbiter sharing one FIFO read port among NUM_REQ consumers in bounded bursts.
// Each word reaches its consumer one cycle after rd_en; a granted consumer's ready low stalls its burst.
module fifo_rd_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_W    = 4
) (
    input  logic                  rd_clk,
    input  logic                  rd_reset,
    input  logic                  arb_en,
    input  logic [BURST_W-1:0]    cfg_burst_len,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    cons_ready,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    cons_valid,
    output logic [DATA_WIDTH-1:0] cons_data,
    output logic                  busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BURST   = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

    logic [1:0]         state;
    logic [IDX_W-1:0]   g_idx;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   winner;
    logic               found;
    logic [BURST_W-1:0] cnt;
    logic [BURST_W-1:0] limit;
    logic [BURST_W-1:0] burst_lim;
    logic               last_issue;
    logic               burst_done;

    // Scan downward so the smallest offset after rr_ptr is the last (winning) assignment.
    always_comb begin
        int pos;
        logic [IDX_W-1:0] pos_i;
        winner = '0;
        found  = 1'b0;
        pos    = 0;
        pos_i  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            pos = int'(rr_ptr) + k;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            pos_i = IDX_W'(pos);
            if (req[pos_i]) begin
                winner = pos_i;
                found  = 1'b1;
            end
        end
    end

    assign burst_lim  = (cfg_burst_len == '0) ? BURST_W'(1) : cfg_burst_len;
    assign fifo_rd_en = (state == BURST) && req[g_idx] && cons_ready[g_idx]
                        && !fifo_empty && (cnt < limit);
    assign last_issue = fifo_rd_en && ((cnt + BURST_W'(1)) == limit);
    assign burst_done = last_issue || !req[g_idx] || (fifo_empty && !fifo_rd_en);
    assign busy       = (state != IDLE);
    assign cons_data  = fifo_rd_data;

    always_ff @(posedge rd_clk or posedge rd_reset) begin
        if (rd_reset) begin
            state      <= IDLE;
            gnt        <= '0;
            g_idx      <= '0;
            rr_ptr     <= IDX_W'(NUM_REQ - 1);
            cnt        <= '0;
            limit      <= '0;
            cons_valid <= '0;
        end else begin
            // Strobe steered by the index held at issue, independent of gnt dropping.
            cons_valid <= fifo_rd_en ? (NUM_REQ'(1) << g_idx) : '0;
            case (state)
                IDLE: begin
                    if (arb_en && found && !fifo_empty) begin
                        state <= BURST;
                        g_idx <= winner;
                        gnt   <= NUM_REQ'(1) << winner;
                        limit <= burst_lim;
                        cnt   <= '0;
                    end
                end
                BURST: begin
                    if (fifo_rd_en) cnt <= cnt + BURST_W'(1);
                    if (burst_done) begin
                        state <= RELEASE;
                        gnt   <= '0;
                    end
                end
                RELEASE: begin
                    rr_ptr <= g_idx;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Bench for fifo_rd_arbiter: FIFO model, word scoreboard, grant-order log, cycle-level corner cases.
module tb_fifo_rd_arbiter;

    logic       rd_clk = 1'b0;
    logic       rd_reset = 1'b0;
    logic       arb_en = 1'b0;
    logic [3:0] cfg_burst_len = 4'd0;
    logic [3:0] req = 4'd0;
    logic [3:0] cons_ready = 4'd0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_rd_data = 8'd0;
    logic       fifo_rd_en;
    logic [3:0] gnt;
    logic [3:0] cons_valid;
    logic [7:0] cons_data;
    logic       busy;

    fifo_rd_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .BURST_W(4)) dut (
        .rd_clk(rd_clk), .rd_reset(rd_reset), .arb_en(arb_en),
        .cfg_burst_len(cfg_burst_len), .req(req), .cons_ready(cons_ready),
        .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
        .fifo_rd_en(fifo_rd_en), .gnt(gnt), .cons_valid(cons_valid),
        .cons_data(cons_data), .busy(busy)
    );

    always #5 rd_clk = ~rd_clk;

    typedef struct packed {
        logic [3:0] cons;
        logic [7:0] dat;
    } exp_t;

    // gseq: expected grant order, one nibble per burst, first burst in nibble 0.
    typedef struct packed {
        logic [3:0]  req;
        logic [3:0]  blen;
        logic [7:0]  nwords;
        logic [3:0]  nb;
        logic [31:0] gseq;
    } vec_t;

    exp_t       sb[$];
    logic [7:0] fq[$];
    logic [3:0] gq[$];
    exp_t       mon_e;
    vec_t       vecs [5];
    int         tests = 0;
    int         fails = 0;
    logic       issue_pending = 1'b0;
    logic [3:0] prev_gnt = 4'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: invariants, grant log, scoreboard compare.
    initial forever begin
        @(negedge rd_clk);
        if (rd_reset) begin
            issue_pending = 1'b0;
            prev_gnt = 4'd0;
        end else begin
            issue_pending = fifo_rd_en;
            if (gnt != 4'd0 && prev_gnt == 4'd0) gq.push_back(gnt);
            prev_gnt = gnt;
            check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            check("valid_onehot0", 32'($onehot0(cons_valid)), 32'd1);
            check("rd_en_safe", 32'(!fifo_rd_en || (!fifo_empty && gnt != 4'd0)), 32'd1);
            if (cons_valid != 4'd0) begin
                if (sb.size() == 0) begin
                    check("extra_valid", 32'(cons_valid), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("word", {20'd0, cons_valid, cons_data}, {20'd0, mon_e.cons, mon_e.dat});
                end
            end
        end
    end

    // FIFO model: a read seen at the negedge pops at the following edge.
    initial forever begin
        @(posedge rd_clk);
        #1;
        if (issue_pending && fq.size() != 0) begin
            fifo_rd_data = fq.pop_front();
            fifo_empty = (fq.size() == 0);
        end
        issue_pending = 1'b0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic nxt();
        @(posedge rd_clk);
        #2;
    endtask

    task automatic do_reset();
        rd_reset = 1'b1;
        req = 4'd0;
        nxt();
        fq.delete();
        sb.delete();
        gq.delete();
        fifo_empty = 1'b1;
        rd_reset = 1'b0;
    endtask

    task automatic load(input int n, input logic [7:0] base, input logic [3:0] cons, input bit expect_it);
        for (int k = 0; k < n; k++) begin
            fq.push_back(base + 8'(k));
            if (expect_it) sb.push_back({cons, 8'(base + 8'(k))});
        end
        fifo_empty = (fq.size() == 0);
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((fq.size() != 0 || busy || sb.size() != 0) && n < budget) begin
            nxt();
            n++;
        end
        check({name, "_drain"}, 32'(n < budget), 32'd1);
    endtask

    task automatic check_gq(input string name, input logic [31:0] seq, input int nb);
        check({name, "_grant_count"}, 32'(gq.size()), 32'(nb));
        for (int i = 0; i < nb; i++)
            check({name, "_grant_order"}, (i < gq.size()) ? 32'(gq[i]) : 32'hFFFF, 32'(seq[i*4 +: 4]));
    endtask

    initial begin
        logic [0:12] en_pat;
        logic [0:12] busy_pat;
        logic [0:4]  rdy_pat;
        logic [7:0]  base;
        int          rem;
        int          eff;
        int          n;

        vecs[0] = '{req: 4'hF, blen: 4'd2,  nwords: 8'd16, nb: 4'd8, gseq: 32'h84218421};
        vecs[1] = '{req: 4'h2, blen: 4'd8,  nwords: 8'd3,  nb: 4'd1, gseq: 32'h00000002};
        vecs[2] = '{req: 4'h5, blen: 4'd0,  nwords: 8'd4,  nb: 4'd4, gseq: 32'h00004141};
        vecs[3] = '{req: 4'hA, blen: 4'd15, nwords: 8'd20, nb: 4'd2, gseq: 32'h00000082};
        vecs[4] = '{req: 4'hC, blen: 4'd3,  nwords: 8'd7,  nb: 4'd3, gseq: 32'h00000484};

        #1 rd_reset = 1'b1;
        @(negedge rd_clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_valid", 32'(cons_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        nxt();
        rd_reset = 1'b0;
        arb_en = 1'b1;
        cons_ready = 4'hF;

        // Single consumer, limit 4, 10 words: two full bursts with a 2-cycle gap, then a short one.
        cfg_burst_len = 4'd4;
        load(10, 8'h00, 4'h1, 1'b1);
        req = 4'h1;
        en_pat   = 13'b0111100111100;
        busy_pat = 13'b0111110111110;
        for (int c = 0; c < 13; c++) begin
            @(negedge rd_clk);
            check("a_rd_en", 32'(fifo_rd_en), 32'(en_pat[c]));
            check("a_busy", 32'(busy), 32'(busy_pat[c]));
            check("a_gnt", 32'(gnt), en_pat[c] ? 32'h1 : 32'h0);
        end
        drain("a", 300);
        check_gq("a", 32'h111, 3);
        req = 4'h0;

        for (int v = 0; v < 5; v++) begin
            do_reset();
            cfg_burst_len = vecs[v].blen;
            rem = int'(vecs[v].nwords);
            eff = (vecs[v].blen == 4'd0) ? 1 : int'(vecs[v].blen);
            base = 8'(v * 32);
            for (int b = 0; b < int'(vecs[v].nb); b++) begin
                n = (rem < eff) ? rem : eff;
                load(n, base, vecs[v].gseq[b*4 +: 4], 1'b1);
                base = base + 8'(n);
                rem = rem - n;
            end
            req = vecs[v].req;
            drain("vec", 400);
            check_gq("vec", vecs[v].gseq, int'(vecs[v].nb));
            req = 4'h0;
        end

        // Ready stall: consumer 2, limit 3, ready 1,0,0,1,1.
        do_reset();
        cfg_burst_len = 4'd3;
        load(3, 8'h40, 4'h4, 1'b1);
        req = 4'h4;
        rdy_pat = 5'b10011;
        for (int c = 0; c < 5; c++) begin
            nxt();
            cons_ready = 4'b1011 | (4'(rdy_pat[c]) << 2);
            @(negedge rd_clk);
            check("b_rd_en", 32'(fifo_rd_en), 32'(rdy_pat[c]));
        end
        nxt();
        cons_ready = 4'hF;
        @(negedge rd_clk);
        check("b_release_busy", 32'(busy), 32'd1);
        check("b_release_gnt", 32'(gnt), 32'd0);
        drain("b", 100);
        check_gq("b", 32'h4, 1);

        // Asynchronous reset in the second issue cycle of a burst to consumer 3.
        do_reset();
        cfg_burst_len = 4'd4;
        load(6, 8'h80, 4'h8, 1'b0);
        req = 4'h8;
        nxt();
        @(negedge rd_clk);
        check("c_gnt", 32'(gnt), 32'h8);
        check("c_rd_en", 32'(fifo_rd_en), 32'd1);
        nxt();
        check("c_valid_pre", 32'(cons_valid), 32'h8);
        check("c_rd_en_pre", 32'(fifo_rd_en), 32'd1);
        #1 rd_reset = 1'b1;
        #1;
        check("c_rst_gnt", 32'(gnt), 32'd0);
        check("c_rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("c_rst_valid", 32'(cons_valid), 32'd0);
        check("c_rst_busy", 32'(busy), 32'd0);
        nxt();
        nxt();
        fq.delete();
        sb.delete();
        gq.delete();
        fifo_empty = 1'b1;
        rd_reset = 1'b0;
        cfg_burst_len = 4'd1;
        load(1, 8'h90, 4'h1, 1'b1);
        load(1, 8'h91, 4'h2, 1'b1);
        req = 4'hF;
        drain("c", 100);
        check_gq("c", 32'h21, 2);
        req = 4'h0;

        // arb_en dropped mid-burst: burst finishes, no new grant, then resumes at the next index.
        do_reset();
        cfg_burst_len = 4'd2;
        load(2, 8'hA0, 4'h1, 1'b1);
        load(2, 8'hA2, 4'h2, 1'b1);
        load(2, 8'hA4, 4'h4, 1'b1);
        load(2, 8'hA6, 4'h8, 1'b1);
        arb_en = 1'b1;
        req = 4'hF;
        nxt();
        nxt();
        arb_en = 1'b0;
        for (int c = 3; c < 10; c++) begin
            nxt();
            @(negedge rd_clk);
            check("d_busy", 32'(busy), (c == 3) ? 32'd1 : 32'd0);
            check("d_gnt", 32'(gnt), 32'd0);
            check("d_rd_en", 32'(fifo_rd_en), 32'd0);
        end
        nxt();
        arb_en = 1'b1;
        drain("d", 200);
        check_gq("d", 32'h8421, 4);
        req = 4'h0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
